// File: rtl/mul_array_arbiter_if.sv
// rtl/mul_array_arbiter_if.sv - requester, multiplier and response signal bundle for mul_array_arbiter
interface mul_array_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    localparam int CW = $clog2(WIDTH + 3);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_y;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_y;
    logic [CW-1:0]         in_flight;
    logic                  idle;

    // Requesters plus the multiplier model drive this side.
    modport master (
        output req_valid, req_a, req_b, mul_y,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_y, in_flight, idle
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_a, req_b, mul_y,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_y, in_flight, idle
    );
endinterface

// File: rtl/mul_array_arbiter.sv
// rtl/mul_array_arbiter.sv - round-robin sharing of one pipelined multiplier between NREQ requesters
module mul_array_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_array_arbiter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 3);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     grant_idx;
    logic               grant_found;
    logic               issue;
    logic [IDW:0]       cand;
    logic [WIDTH:0]     vld;
    logic [IDW-1:0]     tag [0:WIDTH];
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [2*WIDTH-1:0] rsp_y_q;
    logic [CW-1:0]      in_flight_q;

    // First valid requester at or after ptr, wrapping at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Nothing is granted while reset is held, so no operation enters the pipe.
    assign issue = grant_found & rst_n;

    // One-hot grant and operand steering; zero operands when idle.
    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && grant_idx == IDW'(i)) begin
                bus.req_ready[i] = 1'b1;
                bus.mul_a        = bus.req_a[i*WIDTH +: WIDTH];
                bus.mul_b        = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Priority pointer moves to the requester just after the one served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // Valid shadow of the multiplier pipe; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld <= {vld[WIDTH-1:0], issue};
        end
    end

    // Tag shadow; only meaningful where the matching vld bit is set.
    always_ff @(posedge clk) begin
        tag[0] <= grant_idx;
        for (int k = 1; k <= WIDTH; k++) begin
            tag[k] <= tag[k-1];
        end
    end

    // Capture the product when its tag reaches the end of the shadow pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
        end else begin
            rsp_valid_q <= vld[WIDTH];
            if (vld[WIDTH]) begin
                rsp_id_q <= tag[WIDTH];
                rsp_y_q  <= bus.mul_y;
            end
        end
    end

    // Outstanding count: up on issue, down on the edge that delivers a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_flight_q <= '0;
        end else begin
            case ({issue, vld[WIDTH]})
                2'b10:   in_flight_q <= in_flight_q + CW'(1);
                2'b01:   in_flight_q <= in_flight_q - CW'(1);
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.in_flight = in_flight_q;
    assign bus.idle      = (in_flight_q == '0) && !issue;
endmodule

// File: tb/tb_mul_array_arbiter.sv
// tb/tb_mul_array_arbiter.sv - self-checking bench for mul_array_arbiter
module tb_mul_array_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int NV    = 15;

    logic clk;
    logic rst_n;

    mul_array_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    mul_array_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product visible only in the cycle after edge E+WIDTH.
    logic [2*WIDTH-1:0] mp [0:WIDTH];
    always @(posedge clk) begin
        mp[0] <= 16'(bus.mul_a) * 16'(bus.mul_b);
        for (int k = 1; k <= WIDTH; k++) mp[k] <= mp[k-1];
    end
    assign bus.mul_y = mp[WIDTH];

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Scoreboard of issued operations awaiting response.
    typedef struct { int id; int y; } rsp_t;
    rsp_t sb[$];
    bit   mon_en = 1'b0;
    int   mptr   = 0;

    always @(negedge clk) begin
        int   g;
        int   ea;
        int   eb;
        rsp_t r;
        if (mon_en) begin
            g = -1;
            if (rst_n) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && bus.req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
                end
            end
            ea = (g < 0) ? 0 : int'(bus.req_a[g*WIDTH +: WIDTH]);
            eb = (g < 0) ? 0 : int'(bus.req_b[g*WIDTH +: WIDTH]);
            chk("mon_grant", bus.req_ready, (g < 0) ? 0 : (1 << g));
            chk("mon_mul_a", bus.mul_a, ea);
            chk("mon_mul_b", bus.mul_b, eb);
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("mon_rsp_extra", bus.rsp_valid, 0);
                end else begin
                    r = sb.pop_front();
                    chk("mon_rsp_id", bus.rsp_id, r.id);
                    chk("mon_rsp_y", bus.rsp_y, r.y);
                end
            end
            chk("mon_in_flight", bus.in_flight, sb.size());
            chk("mon_idle", bus.idle, (sb.size() == 0 && g < 0) ? 1 : 0);
            if (!rst_n) begin
                sb.delete();
                mptr = 0;
            end else if (g >= 0) begin
                r.id = g;
                r.y  = ea * eb;
                sb.push_back(r);
                mptr = (g + 1) % NREQ;
            end
        end
    end

    typedef struct {
        logic [NREQ-1:0]       v;
        logic [NREQ*WIDTH-1:0] a;
        logic [NREQ*WIDTH-1:0] b;
        logic [NREQ-1:0]       g;
        int                    ma;
        int                    mb;
        bit                    rv;
        int                    id;
        int                    y;
    } vec_t;

    vec_t vt [NV];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return WIDTH'($urandom_range(0, 255));
    endfunction

    logic [NREQ-1:0]       pend;
    logic [NREQ-1:0]       granted;
    logic [NREQ*WIDTH-1:0] ta;
    logic [NREQ*WIDTH-1:0] tbv;

    initial begin
        // Rotating all-valid burst: a=i+1, b=255, ptr starting at 0.
        for (int i = 0; i < 8; i++) begin
            vt[i] = '{4'b1111, 32'h04030201, 32'hFFFFFFFF, 4'(1 << (i % 4)),
                      (i % 4) + 1, 255, 1'b1, i % 4, ((i % 4) + 1) * 255};
        end
        vt[8]  = '{4'b0100, 32'h000D0000, 32'h000B0000, 4'b0100, 13, 11, 1'b1, 2, 143};
        vt[9]  = '{4'b1000, 32'hFF000000, 32'hFF000000, 4'b1000, 255, 255, 1'b1, 3, 65025};
        vt[10] = '{4'b1001, 32'h07000000, 32'h090000C8, 4'b0001, 0, 200, 1'b1, 0, 0};
        vt[11] = '{4'b1001, 32'h07000000, 32'h090000C8, 4'b1000, 7, 9, 1'b1, 3, 63};
        vt[12] = '{4'b0010, 32'h00000100, 32'h00000100, 4'b0010, 1, 1, 1'b1, 1, 1};
        vt[13] = '{4'b0011, 32'h00000905, 32'h00000906, 4'b0001, 5, 6, 1'b1, 0, 30};
        vt[14] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 0, 0, 1'b0, 0, 0};

        // Reset state, including no grant while reset is held.
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = 32'h11223344;
        bus.req_b     = 32'h55667788;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        next_cycle();
        next_cycle();
        rst_n         = 1'b1;
        bus.req_valid = '0;
        mon_en        = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_y", bus.rsp_y, 0);
        chk("rst_in_flight", bus.in_flight, 0);
        chk("rst_idle", bus.idle, 1);

        // Single request from requester 2.
        next_cycle();
        bus.req_valid = 4'b0100;
        bus.req_a     = 32'h000D0000;
        bus.req_b     = 32'h000B0000;
        @(negedge clk);
        chk("single_ready", bus.req_ready, 4'b0100);
        chk("single_idle", bus.idle, 0);
        chk("single_mul_a", bus.mul_a, 13);
        chk("single_mul_b", bus.mul_b, 11);
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            bus.req_valid = '0;
            @(negedge clk);
            chk($sformatf("single_in_flight_t%0d", k), bus.in_flight, (k <= 9) ? 1 : 0);
            chk($sformatf("single_rsp_valid_t%0d", k), bus.rsp_valid, (k == 10) ? 1 : 0);
            if (k == 10) begin
                chk("single_rsp_id", bus.rsp_id, 2);
                chk("single_rsp_y", bus.rsp_y, 143);
            end
        end

        // Table: back-to-back issues, responses exactly 10 cycles later.
        do_reset();
        for (int c = 0; c < NV + 10; c++) begin
            next_cycle();
            if (c < NV) begin
                bus.req_valid = vt[c].v;
                bus.req_a     = vt[c].a;
                bus.req_b     = vt[c].b;
            end else begin
                bus.req_valid = '0;
            end
            @(negedge clk);
            if (c < NV) begin
                chk($sformatf("vec%0d_grant", c), bus.req_ready, vt[c].g);
                chk($sformatf("vec%0d_mul_a", c), bus.mul_a, vt[c].ma);
                chk($sformatf("vec%0d_mul_b", c), bus.mul_b, vt[c].mb);
            end
            if (c >= 10) begin
                chk($sformatf("vec%0d_rsp_valid", c - 10), bus.rsp_valid, vt[c-10].rv);
                if (vt[c-10].rv) begin
                    chk($sformatf("vec%0d_rsp_id", c - 10), bus.rsp_id, vt[c-10].id);
                    chk($sformatf("vec%0d_rsp_y", c - 10), bus.rsp_y, vt[c-10].y);
                end
            end else begin
                chk($sformatf("early_rsp_c%0d", c), bus.rsp_valid, 0);
            end
        end

        // Reset four cycles after the first of three issues: nothing returns.
        next_cycle();
        bus.req_valid = 4'b1111;
        bus.req_a     = 32'h09080706;
        bus.req_b     = 32'h05040302;
        next_cycle();
        next_cycle();
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_flight", bus.in_flight, 0);
        chk("midrst_idle", bus.idle, 1);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                next_cycle();
                @(negedge clk);
            end
            chk($sformatf("midrst_no_rsp_%0d", k), bus.rsp_valid, 0);
        end

        // Random traffic; requesters hold operands until granted or dropped.
        pend    = '0;
        granted = '0;
        ta      = '0;
        tbv     = '0;
        for (int n = 0; n < 10000; n++) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && !granted[i]) begin
                    if ($urandom_range(0, 7) == 0) pend[i] = 1'b0;
                end else begin
                    pend[i] = ($urandom_range(0, 1) == 1);
                    if (pend[i]) begin
                        ta[i*WIDTH +: WIDTH]  = rnd_op();
                        tbv[i*WIDTH +: WIDTH] = rnd_op();
                    end
                end
            end
            bus.req_valid = pend;
            bus.req_a     = ta;
            bus.req_b     = tbv;
            @(negedge clk);
            granted = bus.req_valid & bus.req_ready;
        end
        next_cycle();
        bus.req_valid = '0;
        repeat (15) next_cycle();
        @(negedge clk);
        chk("drain_outstanding", sb.size(), 0);
        chk("drain_in_flight", bus.in_flight, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
